emergency_preempt_arbiter: RTL and testbench

- Arbitrates the two emergency-vehicle request inputs (left and right approach) and sequences the preemption of the traffic light controller.
- Per request: debounces it and latches it as pending. Then runs an all-red clearance, a bounded grant window and a recovery interval.
- Drives the controller's emergency inputs as a clean one-hot grant.
- One clock cycle is 1 s in system timing.

---
 rtl/traffic_pkg.sv | 62 ++++++
 rtl/emergency_preempt_arbiter_if.sv | 20 ++
 rtl/req_debounce.sv | 33 +++
 rtl/emergency_preempt_arbiter.sv | 114 +++++++++++
 tb/tb_emergency_preempt_arbiter.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - shared states, directions, timing defaults and helpers for preemption
package traffic_pkg;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] CLEAR   = 2'd1;
    localparam logic [1:0] GRANT   = 2'd2;
    localparam logic [1:0] RECOVER = 2'd3;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    localparam int DEF_DEBOUNCE       = 2;
    localparam int DEF_CLEAR_CYCLES   = 3;
    localparam int DEF_MIN_HOLD       = 10;
    localparam int DEF_MAX_HOLD       = 60;
    localparam int DEF_RECOVER_CYCLES = 5;
    localparam int DEF_CNT_W          = 8;

    typedef struct packed {
        logic grant_left;
        logic grant_right;
        logic all_red;
        logic buzzer;
        logic busy;
    } arb_out_t;

    function automatic arb_out_t decode_outputs(logic [1:0] st, logic sel);
        arb_out_t o;
        o = '0;
        case (st)
            CLEAR: begin
                o.all_red = 1'b1;
                o.buzzer  = 1'b1;
                o.busy    = 1'b1;
            end
            GRANT: begin
                o.grant_left  = (sel == DIR_LEFT);
                o.grant_right = (sel == DIR_RIGHT);
                o.buzzer      = 1'b1;
                o.busy        = 1'b1;
            end
            RECOVER: begin
                o.all_red = 1'b1;
                o.busy    = 1'b1;
            end
            default: o = '0;
        endcase
        return o;
    endfunction

    // On a tie the direction served less recently wins.
    function automatic logic pick_winner(logic pend_left, logic pend_right, logic last_served);
        if (pend_left && pend_right) begin
            return ~last_served;
        end else if (pend_left) begin
            return DIR_LEFT;
        end else begin
            return DIR_RIGHT;
        end
    endfunction

endpackage

// File: rtl/emergency_preempt_arbiter_if.sv
// rtl/emergency_preempt_arbiter_if.sv - request inputs and preemption outputs of the arbiter
interface emergency_preempt_arbiter_if;
    logic req_left;
    logic req_right;
    logic grant_left;
    logic grant_right;
    logic all_red;
    logic buzzer;
    logic busy;

    modport master (
        output req_left, req_right,
        input  grant_left, grant_right, all_red, buzzer, busy
    );

    modport slave (
        input  req_left, req_right,
        output grant_left, grant_right, all_red, buzzer, busy
    );
endinterface

// File: rtl/req_debounce.sv
// rtl/req_debounce.sv - consecutive-high debounce with a sticky pending flag
module req_debounce #(
    parameter int DEBOUNCE = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic req,
    input  logic clr_pend,
    output logic pend
);

    localparam int CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

    logic [CW-1:0] run;

    // Held in clear while the direction is granted, so a stuck request re-latches only afterwards.
    always_ff @(posedge clk) begin
        if (!reset || clr_pend) begin
            run  <= '0;
            pend <= 1'b0;
        end else if (!req) begin
            run <= '0;
        end else if (!pend) begin
            if (run == CW'(DEBOUNCE - 1)) begin
                pend <= 1'b1;
                run  <= '0;
            end else begin
                run <= run + 1'b1;
            end
        end
    end

endmodule

// File: rtl/emergency_preempt_arbiter.sv
// rtl/emergency_preempt_arbiter.sv - debounces two emergency requests and sequences clear/grant/recover
module emergency_preempt_arbiter
    import traffic_pkg::*;
#(
    parameter int DEBOUNCE       = DEF_DEBOUNCE,
    parameter int CLEAR_CYCLES   = DEF_CLEAR_CYCLES,
    parameter int MIN_HOLD       = DEF_MIN_HOLD,
    parameter int MAX_HOLD       = DEF_MAX_HOLD,
    parameter int RECOVER_CYCLES = DEF_RECOVER_CYCLES,
    parameter int CNT_W          = DEF_CNT_W
) (
    input logic                        clk,
    input logic                        reset,
    emergency_preempt_arbiter_if.slave bus
);

    logic [1:0]       state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             sel, sel_n;
    logic             last_served, last_n;
    logic             pend_left, pend_right;
    logic             req_sel, pend_opp;
    logic             clr_left, clr_right;
    arb_out_t         outs;

    req_debounce #(.DEBOUNCE(DEBOUNCE)) u_deb_left (
        .clk      (clk),
        .reset    (reset),
        .req      (bus.req_left),
        .clr_pend (clr_left),
        .pend     (pend_left)
    );

    req_debounce #(.DEBOUNCE(DEBOUNCE)) u_deb_right (
        .clk      (clk),
        .reset    (reset),
        .req      (bus.req_right),
        .clr_pend (clr_right),
        .pend     (pend_right)
    );

    always_comb begin
        state_n  = state;
        cnt_n    = cnt + 1'b1;
        sel_n    = sel;
        last_n   = last_served;
        req_sel  = (sel == DIR_LEFT) ? bus.req_left : bus.req_right;
        pend_opp = (sel == DIR_LEFT) ? pend_right : pend_left;
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (pend_left || pend_right) begin
                    state_n = CLEAR;
                    sel_n   = pick_winner(pend_left, pend_right, last_served);
                end
            end
            CLEAR: begin
                if (cnt == CNT_W'(CLEAR_CYCLES - 1)) begin
                    state_n = GRANT;
                    cnt_n   = '0;
                    last_n  = sel;
                end
            end
            GRANT: begin
                if ((cnt >= CNT_W'(MIN_HOLD - 1) && !req_sel) || cnt == CNT_W'(MAX_HOLD - 1)) begin
                    cnt_n = '0;
                    // A waiting opposite request goes straight to clearance, skipping recovery.
                    if (pend_opp) begin
                        state_n = CLEAR;
                        sel_n   = ~sel;
                    end else begin
                        state_n = RECOVER;
                    end
                end
            end
            RECOVER: begin
                if (cnt == CNT_W'(RECOVER_CYCLES - 1)) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    assign clr_left  = (state_n == GRANT) && (sel_n == DIR_LEFT);
    assign clr_right = (state_n == GRANT) && (sel_n == DIR_RIGHT);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            cnt         <= '0;
            sel         <= DIR_LEFT;
            last_served <= DIR_RIGHT;
            outs        <= '0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            sel         <= sel_n;
            last_served <= last_n;
            outs        <= decode_outputs(state_n, sel_n);
        end
    end

    assign bus.grant_left  = outs.grant_left;
    assign bus.grant_right = outs.grant_right;
    assign bus.all_red     = outs.all_red;
    assign bus.buzzer      = outs.buzzer;
    assign bus.busy        = outs.busy;

endmodule

// File: tb/tb_emergency_preempt_arbiter.sv
// tb/tb_emergency_preempt_arbiter.sv - directed and random stimulus against a phase-level reference model
module tb_emergency_preempt_arbiter;

    localparam int P_DEB   = 2;
    localparam int P_CLEAR = 3;
    localparam int P_MIN   = 10;
    localparam int P_MAX   = 60;
    localparam int P_REC   = 5;

    localparam int PH_IDLE    = 0;
    localparam int PH_CLEAR   = 1;
    localparam int PH_GRANT   = 2;
    localparam int PH_RECOVER = 3;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    emergency_preempt_arbiter_if bus();

    emergency_preempt_arbiter #(
        .DEBOUNCE       (P_DEB),
        .CLEAR_CYCLES   (P_CLEAR),
        .MIN_HOLD       (P_MIN),
        .MAX_HOLD       (P_MAX),
        .RECOVER_CYCLES (P_REC),
        .CNT_W          (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: phase, cycles completed in phase, served direction, debounce runs.
    int m_phase = PH_IDLE;
    int m_done  = 0;
    int m_dir   = 0;
    int m_last  = 1;
    int m_run[2];
    bit m_pend[2];

    task automatic model_step(input bit rl, input bit rr, input bit rst);
        bit rq[2];
        int nphase, ndone, ndir;
        rq[0] = rl;
        rq[1] = rr;
        if (!rst) begin
            m_phase = PH_IDLE; m_done = 0; m_dir = 0; m_last = 1;
            m_run[0] = 0; m_run[1] = 0; m_pend[0] = 0; m_pend[1] = 0;
            return;
        end
        nphase = m_phase;
        ndone  = m_done + 1;
        ndir   = m_dir;
        case (m_phase)
            PH_IDLE: begin
                ndone = 0;
                if (m_pend[0] || m_pend[1]) begin
                    nphase = PH_CLEAR;
                    if (m_pend[0] && m_pend[1]) ndir = 1 - m_last;
                    else ndir = m_pend[0] ? 0 : 1;
                end
            end
            PH_CLEAR: if (ndone == P_CLEAR) begin
                nphase = PH_GRANT; ndone = 0; m_last = m_dir;
            end
            PH_GRANT: if ((ndone >= P_MIN && !rq[m_dir]) || ndone == P_MAX) begin
                ndone = 0;
                if (m_pend[1 - m_dir]) begin
                    nphase = PH_CLEAR; ndir = 1 - m_dir;
                end else begin
                    nphase = PH_RECOVER;
                end
            end
            default: if (ndone == P_REC) begin
                nphase = PH_IDLE; ndone = 0;
            end
        endcase
        for (int d = 0; d < 2; d++) begin
            if (nphase == PH_GRANT && ndir == d) begin
                m_run[d] = 0; m_pend[d] = 0;
            end else if (!rq[d]) begin
                m_run[d] = 0;
            end else if (!m_pend[d]) begin
                m_run[d]++;
                if (m_run[d] == P_DEB) begin
                    m_pend[d] = 1; m_run[d] = 0;
                end
            end
        end
        m_phase = nphase; m_done = ndone; m_dir = ndir;
    endtask

    int gl_run = 0;
    int gl_lens[$];
    int first_dir = -1;

    task automatic cycle(input bit rl, input bit rr, input bit rst);
        @(negedge clk);
        bus.req_left  = rl;
        bus.req_right = rr;
        reset         = rst;
        @(posedge clk);
        model_step(rl, rr, rst);
        #1;
        check("grant_left",  bus.grant_left,  (m_phase == PH_GRANT && m_dir == 0));
        check("grant_right", bus.grant_right, (m_phase == PH_GRANT && m_dir == 1));
        check("all_red",     bus.all_red,     (m_phase == PH_CLEAR || m_phase == PH_RECOVER));
        check("buzzer",      bus.buzzer,      (m_phase == PH_CLEAR || m_phase == PH_GRANT));
        check("busy",        bus.busy,        (m_phase != PH_IDLE));
        check("onehot",      bus.grant_left & bus.grant_right, 0);
        if (bus.grant_left) begin
            gl_run++;
        end else if (gl_run > 0) begin
            gl_lens.push_back(gl_run);
            gl_run = 0;
        end
        if (first_dir < 0 && bus.grant_left)  first_dir = 0;
        if (first_dir < 0 && bus.grant_right) first_dir = 1;
    endtask

    task automatic hold(input bit rl, input bit rr, input int n);
        for (int i = 0; i < n; i++) cycle(rl, rr, 1'b1);
    endtask

    bit seen;
    int seg_len;
    bit rl_r, rr_r;

    initial begin
        bus.req_left  = 1'b0;
        bus.req_right = 1'b0;
        m_run[0] = 0; m_run[1] = 0; m_pend[0] = 0; m_pend[1] = 0;

        // Idle after reset
        cycle(1'b0, 1'b0, 1'b0);
        check("reset_outs", {bus.grant_left, bus.grant_right, bus.all_red, bus.buzzer, bus.busy}, 0);
        hold(1'b0, 1'b0, 50);

        // Single left request, then a short pulse that must not latch
        hold(1'b1, 1'b0, 20);
        hold(1'b0, 1'b0, 30);
        hold(1'b1, 1'b0, 1);
        hold(1'b0, 1'b0, 10);
        check("pulse_idle", bus.busy, 0);

        // Early drop is stretched to MIN_HOLD
        gl_lens.delete();
        hold(1'b1, 1'b0, 4);
        hold(1'b0, 1'b0, 40);
        check("min_hold_len", (gl_lens.size() > 0) ? gl_lens[0] : -1, P_MIN);

        // Simultaneous requests after reset: left first, twice
        cycle(1'b0, 1'b0, 1'b0);
        first_dir = -1;
        hold(1'b1, 1'b1, 15);
        hold(1'b0, 1'b0, 60);
        check("tie1_winner", first_dir, 0);
        first_dir = -1;
        hold(1'b1, 1'b1, 15);
        hold(1'b0, 1'b0, 60);
        check("tie2_winner", first_dir, 0);

        // Stuck request capped at MAX_HOLD, then with a late right request
        gl_lens.delete();
        hold(1'b1, 1'b0, 100);
        hold(1'b0, 1'b0, 60);
        check("max_hold_len", (gl_lens.size() > 0) ? gl_lens[0] : -1, P_MAX);
        check("stuck_regrant", gl_lens.size(), 2);
        gl_lens.delete();
        hold(1'b1, 1'b0, 30);
        hold(1'b1, 1'b1, 70);
        hold(1'b0, 1'b0, 80);
        check("stuck_right_len", (gl_lens.size() > 0) ? gl_lens[0] : -1, P_MAX);

        // Reset in the fifth grant cycle
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            cycle(1'b1, 1'b0, 1'b1);
            seen = bus.grant_left;
        end
        check("mid_grant_seen", seen, 1);
        hold(1'b1, 1'b0, 4);
        cycle(1'b0, 1'b0, 1'b0);
        check("mid_reset_outs", {bus.grant_left, bus.grant_right, bus.all_red, bus.buzzer, bus.busy}, 0);
        hold(1'b0, 1'b0, 20);
        check("post_reset_idle", bus.busy, 0);

        // Random segments with occasional resets
        for (int s = 0; s < 45; s++) begin
            rl_r    = $urandom_range(0, 1);
            rr_r    = $urandom_range(0, 1);
            seg_len = $urandom_range(1, 80);
            if ($urandom_range(0, 29) == 0) cycle(rl_r, rr_r, 1'b0);
            hold(rl_r, rr_r, seg_len);
        end
        hold(1'b0, 1'b0, 100);
        check("final_idle", bus.busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
